// File: rtl/field_merge_sched.sv
// Field-order merge scheduler: grants one decoder lane per output FIFO push,
// in ascending protobuf field-index order, with round-robin tie-break and watchdog.
module field_merge_sched #(
    parameter int NUM_SRC        = 4,
    parameter int IDX_W          = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart,
    input  logic                     out_fifo_full,
    output logic                     out_fifo_clr,
    output logic                     out_fifo_push,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*IDX_W-1:0] src_index_q,
    output logic [NUM_SRC-1:0]       src_enable,
    output logic [NUM_SRC-1:0]       src_accepted,
    output logic [IDX_W-1:0]         out_index,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [3:0] {
        S_INIT  = 4'b0001,
        S_WAIT  = 4'b0010,
        S_GRANT = 4'b0100,
        S_ERROR = 4'b1000
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic [NUM_SRC-1:0] sel_q, sel_d;
    logic               inc_q, inc_d;
    logic [PTR_W-1:0]   win_q, win_d;

    logic [IDX_W-1:0]   idx_next;
    logic [IDX_W-1:0]   lane_idx;
    logic [NUM_SRC-1:0] eq_m, nx_m, cand;
    logic               have_win, found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_SRC-1:0] win_oh;
    logic [PTR_W:0]     pos;
    logic               stall_hit;
    logic               gnt_go;

    // Lane classification against the current and the next field index.
    always_comb begin
        idx_next = out_index_q + IDX_W'(1);
        lane_idx = '0;
        eq_m     = '0;
        nx_m     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lane_idx = src_index_q[i*IDX_W +: IDX_W];
            eq_m[i]  = src_valid[i] && (lane_idx == out_index_q);
            nx_m[i]  = src_valid[i] && (lane_idx == idx_next);
        end
        cand     = (|eq_m) ? eq_m : nx_m;
        have_win = |cand;
    end

    // First candidate at or above rr_ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        pos     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_SRC)) begin
                pos = pos - (PTR_W+1)'(NUM_SRC);
            end
            if (!found && cand[pos[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = pos[PTR_W-1:0];
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    assign stall_hit = (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign gnt_go    = (state_q == S_GRANT) && !restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_INIT;
        end else begin
            unique case (state_q)
                S_INIT:  state_d = S_WAIT;
                S_WAIT: begin
                    if (!out_fifo_full && have_win) begin
                        state_d = S_GRANT;
                    end else if (!out_fifo_full && (|src_valid) && stall_hit) begin
                        state_d = S_ERROR;
                    end
                end
                S_GRANT: state_d = S_WAIT;
                S_ERROR: state_d = S_INIT;
                default: state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        out_fifo_clr  = (state_q == S_INIT);
        out_fifo_push = gnt_go;
        src_enable    = gnt_go ? sel_q : '0;
        src_accepted  = gnt_go ? sel_q : '0;
        busy          = (state_q == S_WAIT) || (state_q == S_GRANT);
        out_index     = out_index_q;
        timeout_err   = timeout_err_q;
    end

    // Datapath registers; a restart freezes everything except the sticky flag.
    always_comb begin
        out_index_d   = out_index_q;
        rr_ptr_d      = rr_ptr_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = timeout_err_q;
        sel_d         = sel_q;
        inc_d         = inc_q;
        win_d         = win_q;
        if (state_q == S_ERROR) begin
            timeout_err_d = 1'b1;
        end
        if (!restart) begin
            unique case (state_q)
                S_INIT: begin
                    out_index_d = '0;
                    stall_cnt_d = '0;
                end
                S_WAIT: begin
                    if (!out_fifo_full) begin
                        if (have_win) begin
                            sel_d = win_oh;
                            inc_d = ~(|eq_m);
                            win_d = win_idx;
                        end else if (|src_valid) begin
                            stall_cnt_d = stall_cnt_q + CNT_W'(1);
                        end else begin
                            stall_cnt_d = '0;
                        end
                    end
                end
                S_GRANT: begin
                    if (inc_q) begin
                        out_index_d = out_index_q + IDX_W'(1);
                    end
                    rr_ptr_d = (win_q == PTR_W'(NUM_SRC - 1)) ? '0 : win_q + PTR_W'(1);
                    stall_cnt_d = '0;
                end
                S_ERROR: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_index_q   <= '0;
            rr_ptr_q      <= '0;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            sel_q         <= '0;
            inc_q         <= 1'b0;
            win_q         <= '0;
        end else begin
            out_index_q   <= out_index_d;
            rr_ptr_q      <= rr_ptr_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
            sel_q         <= sel_d;
            inc_q         <= inc_d;
            win_q         <= win_d;
        end
    end

endmodule
